fifo_sync_param: RTL
====================

// Module: fifo_sync_param
// PURPOSE
//  Parametrised single-clock FIFO for buffering pixel/SAD data between pipeline stages of the full-search engine.
//  Generalises the fixed 256x8 FIFO to any power-of-two DEPTH and any WIDTH.
//  Adds a correct full/empty-aware occupancy count, almost-full/almost-empty thresholds and a read-data-valid strobe.
//  Optionally adds sticky overflow/underflow error flags.
// PARAMETERS
//  WIDTH      8    data word width in bits (>=1)
//  DEPTH      256  number of entries; power of two, >=4
//  AF_THRESH  224  almost_full asserted when FIFO_count >= AF_THRESH (1..DEPTH)
//  AE_THRESH  32   almost_empty asserted when FIFO_count <= AE_THRESH (0..DEPTH-1)
//  (derived) AW = $clog2(DEPTH); count width CW = AW+1
// PORTS
//  clk           in   1      rising-edge clock
//  rst           in   1      asynchronous, active-high reset
//  wr            in   1      write request
//  data_in       in   WIDTH  write data, sampled on clk when write accepted
//  rd            in   1      read request
//  data_out      out  WIDTH  registered read data
//  data_valid    out  1      1-cycle pulse: data_out updated by an accepted read
//  empty         out  1      FIFO_count == 0
//  full          out  1      FIFO_count == DEPTH
//  almost_empty  out  1      FIFO_count <= AE_THRESH
//  almost_full   out  1      FIFO_count >= AF_THRESH
//  FIFO_count    out  CW     current occupancy, 0..DEPTH
//  overflow      out  1      sticky; present only with FIFO_ERR_FLAGS_EN
//  underflow     out  1      sticky; present only with FIFO_ERR_FLAGS_EN
// BEHAVIOUR
//  - Reset (async assert, sync release): wr_ptr=rd_ptr=0, FIFO_count=0, data_out=0, data_valid=0.
//    Reset also forces empty=1, full=0, almost_empty=1, almost_full=(AF_THRESH==0 ? 1 : 0), overflow=underflow=0.
//    Storage array is not reset. Reset mid-operation discards all contents immediately.
//  - rd_acc = rd & !empty.
//  - wr_acc = wr & (!full | rd_acc); a write at full proceeds only when paired with an accepted read.
//  - Pointers AW bits, wrap DEPTH-1 -> 0 naturally.
//  - wr_ptr increments on wr_acc; rd_ptr increments on rd_acc.
//  - FIFO_count: +1 on wr_acc & !rd_acc; -1 on rd_acc & !wr_acc; otherwise unchanged. Never exceeds DEPTH or goes below 0.
//  - Status flags are combinational decodes of the registered FIFO_count, valid in the same cycle the count changes.
//  - Read latency 1: on rd_acc at edge N, data_out = mem[rd_ptr] and data_valid=1 after edge N.
//    data_valid returns to 0 next cycle unless another rd_acc occurs; data_out holds its last value otherwise.
//  - No read-during-write bypass: a word written at edge N is readable from edge N+1.
//  - Simultaneous rd & wr:
//      empty -> write only, count 0->1, data_valid stays 0.
//      full -> both accepted, count stays DEPTH.
//      otherwise -> both accepted, count unchanged.
//  - Rejected requests (wr at full without rd_acc, rd at empty) change no state.
// CONFIGURATION
//  `define FIFO_ERR_FLAGS_EN:
//    - overflow/underflow ports exist.
//    - overflow sets on wr & full & !rd_acc.
//    - underflow sets on rd & empty.
//    - Both are sticky until rst.
//  Macro undefined: ports absent; rejected requests are silently dropped; all other behaviour identical.
// TESTING  (WIDTH=8, DEPTH=16, AF_THRESH=12, AE_THRESH=2)
//  1. Fill 3 words, pulse rst between edges
//     -> FIFO_count=0, empty=1, data_valid=0 before next edge; subsequent read rejected.
//  2. Write 0x01..0x10 -> full=1, FIFO_count=16 after 16th write.
//     17th wr (rd=0) -> count stays 16, overflow=1 with macro.
//  3. From full, read 16 -> data_out 0x01..0x10 in order, data_valid 1 cycle after each rd, empty=1 at end.
//     Extra rd -> no data_valid, underflow=1.
//  4. At full, rd=wr=1 with 0xAA -> count 16, data_out=oldest word; 0xAA read back last.
//     At empty, rd=wr=1 with 0x55 -> count 1, data_valid=0.
//  5. 40 interleaved random wr/rd with incrementing data -> output sequence matches input order across pointer wrap.
//  6. Thresholds: almost_full rises when count 11->12, falls 12->11; almost_empty falls when count 2->3, rises 3->2.

Source files
------------

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags and a read-data-valid strobe.
// Define FIFO_ERR_FLAGS_EN to add sticky overflow/underflow ports.
module fifo_sync_param #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned AF_THRESH = 224,
    parameter int unsigned AE_THRESH = 32,
    localparam int unsigned AW       = $clog2(DEPTH),
    localparam int unsigned CW       = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [WIDTH-1:0] data_in,
    input  logic             rd,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             empty,
    output logic             full,
    output logic             almost_empty,
    output logic             almost_full,
    output logic [CW-1:0]    FIFO_count
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic             overflow,
    output logic             underflow
`endif
);

    localparam logic [CW-1:0] DepthC = CW'(DEPTH);
    localparam logic [CW-1:0] AfC    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AeC    = CW'(AE_THRESH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] data_out_q;
    logic             data_valid_q;
    logic             rd_acc, wr_acc;

    // Flags decode the registered count so they track it in the same cycle.
    always_comb begin
        empty        = (count_q == '0);
        full         = (count_q == DepthC);
        almost_empty = (count_q <= AeC);
        almost_full  = (count_q >= AfC);
    end

    always_comb begin
        rd_acc   = rd & ~empty;
        // A write at full is only safe when a read frees a slot on the same edge.
        wr_acc   = wr & (~full | rd_acc);
        wr_ptr_d = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (wr_acc && !rd_acc) begin
            count_d = count_q + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            data_valid_q <= rd_acc;
            if (rd_acc) begin
                data_out_q <= mem[rd_ptr_q];
            end
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign FIFO_count = count_q;

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q, underflow_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr && full && !rd_acc) overflow_q <= 1'b1;
            if (rd && empty) underflow_q <= 1'b1;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule
